vga_sync_gen: RTL and testbench

//  Pixel-timing stage feeding the VGA colour/pattern logic. Divides the board clock into a

---
 rtl/vga_sync_gen.sv | 99 +++++++++
 tb/tb_vga_sync_gen.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// 640x480@60 pixel timing: clock-enable divider, h/v counters and
// registered, mutually aligned sync/active/strobe outputs.
module vga_sync_gen #(
    parameter int   CLK_DIV  = 4,
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        pix_en,
    output logic [10:0] h_pixel,
    output logic [9:0]  v_pixel,
    output logic        hsync,
    output logic        vsync,
    output logic        active,
    output logic        line_start,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
    localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC - 1);

    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [DIV_W-1:0] div;
    logic             tick;
    logic [10:0]      h_next;
    logic [9:0]       v_next;

    assign tick   = (div == DIV_MAX);
    // Gated by rst so a held reset never shows a pixel strobe (CLK_DIV=1)
    assign pix_en = tick & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            div <= '0;
        end else if (tick) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    always_comb begin
        h_next = h_pixel + 11'd1;
        v_next = v_pixel;
        if (h_pixel == H_LAST) begin
            h_next = '0;
            v_next = (v_pixel == V_LAST) ? '0 : v_pixel + 10'd1;
        end
    end

    // Everything decodes from the next position so all outputs share one edge
    always_ff @(posedge clk) begin
        if (rst) begin
            h_pixel     <= H_LAST;
            v_pixel     <= V_LAST;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            active      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (tick) begin
                h_pixel     <= h_next;
                v_pixel     <= v_next;
                hsync       <= (h_next >= HS_BEG && h_next <= HS_END)
                               ? HS_POL : ~HS_POL;
                vsync       <= (v_next >= VS_BEG && v_next <= VS_END)
                               ? VS_POL : ~VS_POL;
                active      <= (h_next < H_ACT) && (v_next < V_ACT);
                line_start  <= (h_next == '0);
                frame_start <= (h_next == '0) && (v_next == '0);
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: full-size instance at CLK_DIV=4 plus a
// shrunken-timing instance at CLK_DIV=1 checked against an index model.
module tb_vga_sync_gen;

    typedef struct packed {
        logic        pix_en;
        logic [10:0] h;
        logic [9:0]  v;
        logic        hs;
        logic        vs;
        logic        act;
        logic        ls;
        logic        fs;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        m_pe, m_hs, m_vs, m_act, m_ls, m_fs;
    logic [10:0] m_h;
    logic [9:0]  m_v;
    logic        s_pe, s_hs, s_vs, s_act, s_ls, s_fs;
    logic [10:0] s_h;
    logic [9:0]  s_v;

    int cmp_cnt = 0;
    int mis_cnt = 0;
    int n = 0;

    exp_t q_m[$];
    exp_t q_s[$];

    int m_hs_low, m_ls_cnt, m_fs_cnt, m_pe_cnt;
    int s_pe_cnt, s_act_cnt, s_ls_cnt, s_fs_cnt, s_vs_cnt;

    always #5 clk = ~clk;

    vga_sync_gen dut_m (
        .clk(clk), .rst(rst), .pix_en(m_pe),
        .h_pixel(m_h), .v_pixel(m_v),
        .hsync(m_hs), .vsync(m_vs), .active(m_act),
        .line_start(m_ls), .frame_start(m_fs)
    );

    vga_sync_gen #(
        .CLK_DIV(1),
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut_s (
        .clk(clk), .rst(rst), .pix_en(s_pe),
        .h_pixel(s_h), .v_pixel(s_v),
        .hsync(s_hs), .vsync(s_vs), .active(s_act),
        .line_start(s_ls), .frame_start(s_fs)
    );

    // Expected outputs after n edges since reset, from the pixel index
    function automatic exp_t model(
        int k, bit r, int d,
        int ha, int hf, int hsw, int hb,
        int va, int vf, int vsw, int vb,
        bit hp, bit vp
    );
        int ht, vt, a, p, h, v;
        exp_t e;
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vb;
        a  = r ? 0 : k / d;
        e.pix_en = r ? 1'b0 : ((k % d) == d - 1);
        if (a == 0) begin
            h = ht - 1;
            v = vt - 1;
        end else begin
            p = (a - 1) % (ht * vt);
            h = p % ht;
            v = p / ht;
        end
        e.h   = 11'(h);
        e.v   = 10'(v);
        if (a == 0) begin
            e.hs  = ~hp;
            e.vs  = ~vp;
            e.act = 1'b0;
            e.ls  = 1'b0;
            e.fs  = 1'b0;
        end else begin
            e.hs  = (h >= ha + hf && h < ha + hf + hsw) ? hp : ~hp;
            e.vs  = (v >= va + vf && v < va + vf + vsw) ? vp : ~vp;
            e.act = (h < ha) && (v < va);
            e.ls  = ((k % d) == 0) && (h == 0);
            e.fs  = ((k % d) == 0) && (h == 0) && (v == 0);
        end
        return e;
    endfunction

    task automatic chk(string tag, int got, int want);
        cmp_cnt++;
        assert (got === want) else begin
            mis_cnt++;
            $error("FAIL %s n=%0d observed=%0d expected=%0d",
                   tag, n, got, want);
        end
    endtask

    task automatic cmp(string p, exp_t g, exp_t e);
        chk({p, ".pix_en"}, int'(g.pix_en), int'(e.pix_en));
        chk({p, ".h_pixel"}, int'(g.h), int'(e.h));
        chk({p, ".v_pixel"}, int'(g.v), int'(e.v));
        chk({p, ".hsync"}, int'(g.hs), int'(e.hs));
        chk({p, ".vsync"}, int'(g.vs), int'(e.vs));
        chk({p, ".active"}, int'(g.act), int'(e.act));
        chk({p, ".line_start"}, int'(g.ls), int'(e.ls));
        chk({p, ".frame_start"}, int'(g.fs), int'(e.fs));
    endtask

    task automatic step(bit r);
        exp_t gm, gs;
        rst = r;
        n   = r ? 0 : n + 1;
        q_m.push_back(model(n, r, 4, 640, 16, 96, 48,
                            480, 10, 2, 33, 1'b0, 1'b0));
        q_s.push_back(model(n, r, 1, 8, 2, 3, 2,
                            4, 1, 2, 1, 1'b1, 1'b1));
        @(posedge clk);
        #1;
        gm = '{m_pe, m_h, m_v, m_hs, m_vs, m_act, m_ls, m_fs};
        gs = '{s_pe, s_h, s_v, s_hs, s_vs, s_act, s_ls, s_fs};
        cmp("m", gm, q_m.pop_front());
        cmp("s", gs, q_s.pop_front());
        if (!r && n >= 4 && n < 3204) begin
            m_hs_low += (m_hs == 1'b0) ? 1 : 0;
            m_ls_cnt += int'(m_ls);
            m_fs_cnt += int'(m_fs);
            m_pe_cnt += int'(m_pe);
        end
        if (!r && n >= 1 && n < 121) begin
            s_pe_cnt  += int'(s_pe);
            s_act_cnt += int'(s_act);
            s_ls_cnt  += int'(s_ls);
            s_fs_cnt  += int'(s_fs);
            s_vs_cnt  += int'(s_vs);
        end
    endtask

    initial begin
        m_hs_low = 0; m_ls_cnt = 0; m_fs_cnt = 0; m_pe_cnt = 0;
        s_pe_cnt = 0; s_act_cnt = 0; s_ls_cnt = 0;
        s_fs_cnt = 0; s_vs_cnt = 0;

        repeat (3) step(1'b1);

        // Run past the first line wrap of the full-size timing
        while (n < 3300) step(1'b0);

        chk("m.hsync_low_clks", m_hs_low, 384);
        chk("m.line_starts", m_ls_cnt, 1);
        chk("m.frame_starts", m_fs_cnt, 1);
        chk("m.pix_en_line", m_pe_cnt, 800);

        chk("s.pix_en_frame", s_pe_cnt, 120);
        chk("s.active_frame", s_act_cnt, 32);
        chk("s.line_starts", s_ls_cnt, 8);
        chk("s.frame_starts", s_fs_cnt, 1);
        chk("s.vsync_clks", s_vs_cnt, 30);

        // Reset mid-pixel at (300,1), div=1
        while (n < 4405) step(1'b0);
        chk("m.pre_rst_h", int'(m_h), 300);
        step(1'b1);
        step(1'b1);
        repeat (24) step(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 cmp_cnt, mis_cnt);
        $finish;
    end

endmodule
